// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs instruction fields into 32-bit ARM words and writes them one after
//   another into instruction memory, starting at word 0. Once DEPTH words have
//   been written the loader parks in FULL until reset.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   field-set handshake (accept = in_valid & in_ready)
//   kind                00 data-proc, 01 memory, 10 branch, 11 illegal
//   cond,funct,i_bit,   instruction fields (see encoder below)
//   s_bit,r_w,rd,rn,
//   rm,imm
//   mem_we/addr/wdata   instruction-memory write port
//   count               words written since reset
//   full                all DEPTH words written
//   err                 one-cycle pulse after an illegal kind is rejected
module instr_encoder_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        kind,
  input  logic [3:0]        cond,
  input  logic [3:0]        funct,
  input  logic              i_bit,
  input  logic              s_bit,
  input  logic              r_w,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [23:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_MEM = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       word_q;
  logic [31:0]       enc_word;
  logic              err_q;
  logic              accept;
  logic              last_slot;

  // Field encoder; only the fields belonging to the selected kind reach the word.
  always_comb begin
    enc_word = '0;
    case (kind)
      KIND_DP:  enc_word = {cond, 2'b00, i_bit, funct, s_bit, rn, rd,
                            i_bit ? imm[11:0] : {8'h00, rm}};
      KIND_MEM: enc_word = {cond, 2'b01, i_bit, funct, r_w, rn, rd,
                            i_bit ? {8'h00, rm} : imm[11:0]};
      KIND_BR:  enc_word = {cond, 3'b101, s_bit, imm[23:0]};
      default:  enc_word = '0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign last_slot = (wptr == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (kind != 2'b11)) state_nxt = WRITE;
      WRITE:   state_nxt = last_slot ? FULL : IDLE;
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wptr   <= '0;
      cnt    <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= accept && (kind == 2'b11);
      if (accept && (kind != 2'b11))
        word_q <= enc_word;
      if (state == WRITE) begin
        cnt <= cnt + 1'b1;
        // Pointer saturates on the final slot; FULL prevents any further write.
        if (!last_slot)
          wptr <= wptr + 1'b1;
      end
    end
  end

  // Gating with rst keeps the handshake closed and suppresses a write that
  // coincides with reset, without waiting for the state register to clear.
  assign in_ready  = (state == IDLE)  && !rst;
  assign mem_we    = (state == WRITE) && !rst;
  assign full      = (state == FULL)  && !rst;
  assign mem_addr  = wptr;
  assign mem_wdata = word_q;
  assign count     = cnt;
  assign err       = err_q;

endmodule
